// File: rtl/nec_prefetch_ctrl.sv
// nec_prefetch_ctrl: bus-cycle scheduler and 8-byte instruction prefetch queue.
// Runs 4-T-state cycles (T1..T4, T3 stretched by bus_ready) on a 16-bit bus.
// EU data accesses win arbitration over prefetch. A cycle is never preempted.
// Optional feature macro: BRANCH_HOLDOFF_EN. When defined, block_prefetch
// suppresses prefetch grants while the bus is idle.
module nec_prefetch_ctrl (
   input  logic            clk,
   input  logic            reset,
   input  logic            ce_1,
   input  logic [15:0]     ps,
   input  logic [15:0]     dec_pc,
   input  logic            set_pc,
   input  logic [15:0]     new_pc,
   input  logic            block_prefetch,
   output logic [7:0][7:0] ipq,
   output logic [3:0]      ipq_len,
   input  logic            eu_req,
   input  logic            eu_write,
   input  logic [19:0]     eu_addr,
   input  logic [15:0]     eu_wdata,
   input  logic [1:0]      eu_be,
   output logic            eu_done,
   output logic [15:0]     eu_rdata,
   output logic [19:0]     bus_addr,
   output logic            bus_rd,
   output logic            bus_wr,
   output logic [1:0]      bus_be,
   output logic [15:0]     bus_wdata,
   input  logic [15:0]     bus_rdata,
   input  logic            bus_ready
);

   typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} bus_state_t;

   bus_state_t      state_q;
   logic [15:0]     fetch_pc_q;
   logic [7:0][7:0] ipq_q;
   logic            discard_q;
   logic            owner_eu_q;
   logic            eu_done_q;
   logic [15:0]     eu_rdata_q;
   logic [19:0]     bus_addr_q;
   logic            bus_rd_q;
   logic            bus_wr_q;
   logic [1:0]      bus_be_q;
   logic [15:0]     bus_wdata_q;

   logic [15:0]     fill_diff;
   logic            hold_pf;
   logic            pf_grant_d;
   logic [19:0]     pf_addr_d;
   logic [2:0]      pf_idx;
   logic            pf_cycle;
   logic            unused_bits;

`ifdef BRANCH_HOLDOFF_EN
   assign hold_pf = block_prefetch;
`else
   assign hold_pf = 1'b0;
`endif

   // Only the low four bits of the pointer distance form the fill level; the
   // decoder keeps dec_pc within eight bytes of fetch_pc.
   assign unused_bits = ^{block_prefetch, fill_diff[15:4]};
   assign pf_idx      = fetch_pc_q[2:0];
   assign pf_cycle    = !owner_eu_q && (state_q inside {S_T1, S_T2, S_T3});

   // Fill level and prefetch eligibility; a flush on this edge never opens a
   // prefetch because the cycle would be fetched from the stale pointer.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned, which would infer a latch.
      fill_diff  = fetch_pc_q - dec_pc;
      ipq_len    = fill_diff[3:0];
      pf_addr_d  = {ps, 4'h0} + {4'h0, fetch_pc_q};
      pf_grant_d = 1'b0;
      if (!set_pc && !hold_pf) begin
         pf_grant_d = (ipq_len <= 4'd6) || (fetch_pc_q[0] && (ipq_len <= 4'd7));
      end
   end

   // Bus FSM, arbitration, queue commit and flush handling with registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: the queue bytes sit in ordinary flops, so they are cleared on reset
      // like the rest of the state rather than being left as uninitialised memory.
      if (reset) begin
         state_q     <= S_IDLE;
         fetch_pc_q  <= '0;
         ipq_q       <= '0;
         discard_q   <= 1'b0;
         owner_eu_q  <= 1'b0;
         eu_done_q   <= 1'b0;
         eu_rdata_q  <= '0;
         bus_addr_q  <= '0;
         bus_rd_q    <= 1'b0;
         bus_wr_q    <= 1'b0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
      end else if (ce_1) begin
         // NOTE: state is assigned non-blocking, so later assignments in this
         // block (the flush below) override earlier ones on the same edge.
         eu_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (eu_req) begin
                  owner_eu_q  <= 1'b1;
                  bus_addr_q  <= eu_addr;
                  bus_be_q    <= eu_be;
                  bus_rd_q    <= !eu_write;
                  bus_wr_q    <= eu_write;
                  bus_wdata_q <= eu_write ? eu_wdata : 16'h0000;
                  state_q     <= S_T1;
               end else if (pf_grant_d) begin
                  owner_eu_q  <= 1'b0;
                  bus_addr_q  <= pf_addr_d;
                  bus_be_q    <= fetch_pc_q[0] ? 2'b10 : 2'b11;
                  bus_rd_q    <= 1'b1;
                  bus_wr_q    <= 1'b0;
                  bus_wdata_q <= 16'h0000;
                  state_q     <= S_T1;
               end
            end
            S_T1: state_q <= S_T2;
            S_T2: state_q <= S_T3;
            S_T3: begin
               if (bus_ready) begin
                  if (owner_eu_q) begin
                     eu_done_q  <= 1'b1;
                     eu_rdata_q <= bus_rdata;
                  end else if (!discard_q && !set_pc) begin
                     if (fetch_pc_q[0]) begin
                        ipq_q[pf_idx] <= bus_rdata[15:8];
                        fetch_pc_q    <= fetch_pc_q + 16'd1;
                     end else begin
                        ipq_q[pf_idx]        <= bus_rdata[7:0];
                        ipq_q[pf_idx + 3'd1] <= bus_rdata[15:8];
                        fetch_pc_q           <= fetch_pc_q + 16'd2;
                     end
                  end
                  bus_addr_q  <= '0;
                  bus_rd_q    <= 1'b0;
                  bus_wr_q    <= 1'b0;
                  bus_be_q    <= '0;
                  bus_wdata_q <= '0;
                  state_q     <= S_T4;
               end
            end
            S_T4: begin
               discard_q <= 1'b0;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
         // A flush redirects fetching; an in-flight prefetch finishes on the bus
         // but its data is dropped. EU cycles are unaffected.
         if (set_pc) begin
            fetch_pc_q <= new_pc;
            if (pf_cycle) begin
               discard_q <= 1'b1;
            end
         end
      end
   end

   assign ipq       = ipq_q;
   assign eu_done   = eu_done_q;
   assign eu_rdata  = eu_rdata_q;
   assign bus_addr  = bus_addr_q;
   assign bus_rd    = bus_rd_q;
   assign bus_wr    = bus_wr_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_nec_prefetch_ctrl.sv
// Testbench for nec_prefetch_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model. Memory
// contents come from an address hash so every queue byte can be re-derived.
module tb_nec_prefetch_ctrl;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            ce_1 = 1'b0;
   logic [15:0]     ps = '0;
   logic [15:0]     dec_pc = '0;
   logic            set_pc = 1'b0;
   logic [15:0]     new_pc = '0;
   logic            block_prefetch = 1'b0;
   logic [7:0][7:0] ipq;
   logic [3:0]      ipq_len;
   logic            eu_req = 1'b0;
   logic            eu_write = 1'b0;
   logic [19:0]     eu_addr = '0;
   logic [15:0]     eu_wdata = '0;
   logic [1:0]      eu_be = '0;
   logic            eu_done;
   logic [15:0]     eu_rdata;
   logic [19:0]     bus_addr;
   logic            bus_rd;
   logic            bus_wr;
   logic [1:0]      bus_be;
   logic [15:0]     bus_wdata;
   logic [15:0]     bus_rdata = '0;
   logic            bus_ready = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: bus activity as a transaction with an edge count.
   logic        m_busy, m_tail, m_eu, m_disc, m_done;
   int          m_edges;
   logic [15:0] m_fpc, m_rdata, m_wdata;
   logic [19:0] m_addr;
   logic        m_rd, m_wr;
   logic [1:0]  m_be;

   nec_prefetch_ctrl dut (
      .clk(clk), .reset(reset), .ce_1(ce_1), .ps(ps), .dec_pc(dec_pc),
      .set_pc(set_pc), .new_pc(new_pc), .block_prefetch(block_prefetch),
      .ipq(ipq), .ipq_len(ipq_len), .eu_req(eu_req), .eu_write(eu_write),
      .eu_addr(eu_addr), .eu_wdata(eu_wdata), .eu_be(eu_be), .eu_done(eu_done),
      .eu_rdata(eu_rdata), .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ready(bus_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [19:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ {4'h0, a[19:16]} ^ 8'h3C;
   endfunction

   function automatic logic [15:0] word_at(input logic [19:0] a);
      return {mem_byte({a[19:1], 1'b1}), mem_byte({a[19:1], 1'b0})};
   endfunction

   function automatic logic [3:0] model_len();
      logic [15:0] d;
      d = m_fpc - dec_pc;
      return d[3:0];
   endfunction

   task automatic clear_model_bus();
      m_addr = '0; m_rd = 1'b0; m_wr = 1'b0; m_be = '0; m_wdata = '0;
   endtask

   // Apply the rules to one clock edge using the inputs held across it.
   task automatic model_edge();
      logic       was_busy, room, hold;
      logic [3:0] len;
      if (reset) begin
         m_busy = 0; m_tail = 0; m_eu = 0; m_disc = 0; m_done = 0;
         m_edges = 0; m_fpc = '0; m_rdata = '0;
         clear_model_bus();
         return;
      end
      if (!ce_1) return;
`ifdef BRANCH_HOLDOFF_EN
      hold = block_prefetch;
`else
      hold = 1'b0;
`endif
      m_done   = 1'b0;
      was_busy = m_busy;
      len      = model_len();
      room     = (8 - int'(len) >= 2) || (m_fpc[0] && (8 - int'(len) >= 1));
      if (m_busy) begin
         m_edges++;
         if (m_edges >= 3 && bus_ready) begin
            if (m_eu) begin
               m_done  = 1'b1;
               m_rdata = bus_rdata;
            end else if (!m_disc && !set_pc) begin
               m_fpc = m_fpc + (m_fpc[0] ? 16'd1 : 16'd2);
            end
            m_busy = 0; m_tail = 1;
            clear_model_bus();
         end
      end else if (m_tail) begin
         m_tail = 0; m_disc = 0;
      end else if (eu_req) begin
         m_busy = 1; m_eu = 1; m_edges = 0;
         m_addr = eu_addr; m_be = eu_be; m_rd = !eu_write; m_wr = eu_write;
         m_wdata = eu_write ? eu_wdata : 16'h0;
      end else if (room && !set_pc && !hold) begin
         m_busy = 1; m_eu = 0; m_edges = 0;
         m_addr = {ps, 4'h0} + {4'h0, m_fpc};
         m_be = m_fpc[0] ? 2'b10 : 2'b11; m_rd = 1'b1; m_wr = 1'b0; m_wdata = '0;
      end
      if (set_pc) begin
         m_fpc = new_pc;
         if (was_busy && !m_eu) m_disc = 1'b1;
      end
   endtask

   task automatic compare();
      logic [3:0]  len;
      logic [19:0] a;
      check("bus_addr", 64'(bus_addr), 64'(m_addr));
      check("bus_rd", 64'(bus_rd), 64'(m_rd));
      check("bus_wr", 64'(bus_wr), 64'(m_wr));
      check("bus_be", 64'(bus_be), 64'(m_be));
      check("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
      check("eu_done", 64'(eu_done), 64'(m_done));
      check("eu_rdata", 64'(eu_rdata), 64'(m_rdata));
      len = model_len();
      check("ipq_len", 64'(ipq_len), 64'(len));
      if (len <= 4'd8) begin
         for (int k = 0; k < int'(len); k++) begin
            a = {ps, 4'h0} + {4'h0, dec_pc} + 20'(k);
            check("ipq_byte", 64'(ipq[a[2:0]]), 64'(mem_byte(a)));
         end
      end
      bus_rdata = word_at(bus_addr);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic drive_random(input bit rnd_ce, input bit use_eu, input bit use_flush);
      logic [3:0] len;
      ce_1           = rnd_ce ? ($urandom_range(0, 7) != 0) : 1'b1;
      bus_ready      = ($urandom_range(0, 3) != 0);
      block_prefetch = ($urandom_range(0, 3) == 0);
      if (eu_req && eu_done) begin
         eu_req = 1'b0;
      end else if (use_eu && !eu_req && !eu_done && $urandom_range(0, 15) == 0) begin
         eu_req   = 1'b1;
         eu_write = 1'($urandom);
         eu_addr  = 20'($urandom);
         eu_wdata = 16'($urandom);
         eu_be    = 2'($urandom);
      end
      if (use_flush && ce_1 && $urandom_range(0, 39) == 0) begin
         set_pc = 1'b1;
         new_pc = 16'($urandom);
         if ($urandom_range(0, 3) == 0) ps = 16'($urandom);
         dec_pc = new_pc;
      end else begin
         set_pc = 1'b0;
         len = model_len();
         if (len != 0 && len <= 4'd8 && $urandom_range(0, 1) == 1)
            dec_pc = dec_pc + 16'($urandom_range(1, (len > 3) ? 3 : int'(len)));
      end
   endtask

   initial begin
      int guard;
      // Reset with clock enable low: reset must act regardless.
      repeat (3) tick();
      check("ipq_reset", 64'(ipq), 64'h0);
      check("ipq_len_reset", 64'(ipq_len), 64'h0);

      // Fill from address 0 with zero waits.
      reset = 1'b0; ce_1 = 1'b1; bus_ready = 1'b1;
      tick();
      check("first_addr", 64'(bus_addr), 64'h0);
      check("first_be", 64'(bus_be), 64'h3);
      check("first_rd", 64'(bus_rd), 64'h1);
      repeat (3) tick();
      check("first_len", 64'(ipq_len), 64'h2);
      check("first_b0", 64'(ipq[0]), 64'(mem_byte(20'h0)));
      check("first_b1", 64'(ipq[1]), 64'(mem_byte(20'h1)));
      repeat (40) tick();
      check("full_len", 64'(ipq_len), 64'h8);
      check("full_no_rd", 64'(bus_rd), 64'h0);

      // Flush to an odd pointer in a new segment.
      set_pc = 1'b1; new_pc = 16'h0013; ps = 16'h1000; dec_pc = 16'h0013;
      tick();
      set_pc = 1'b0;
      tick();
      check("odd_addr", 64'(bus_addr), 64'h10013);
      check("odd_be", 64'(bus_be), 64'h2);
      repeat (3) tick();
      check("odd_byte", 64'(ipq[3]), 64'(mem_byte(20'h10013)));
      repeat (2) tick();
      check("even_addr", 64'(bus_addr), 64'h10014);
      check("even_be", 64'(bus_be), 64'h3);

      // Flush while the prefetch is stalled in T3.
      bus_ready = 1'b0;
      repeat (3) tick();
      set_pc = 1'b1; new_pc = 16'h0040; dec_pc = 16'h0040;
      tick();
      set_pc = 1'b0; bus_ready = 1'b1;
      tick();
      check("discard_len", 64'(ipq_len), 64'h0);
      check("discard_keep", 64'(ipq[4]), 64'(mem_byte(20'h4)));
      repeat (2) tick();
      check("refetch_addr", 64'(bus_addr), 64'h10040);

      // EU write competing with a prefetch opportunity.
      guard = 0;
      while ((m_busy || m_tail) && guard < 20) begin tick(); guard++; end
      check("idle_reached", 64'(m_busy || m_tail), 64'h0);
      dec_pc = m_fpc;
      eu_req = 1'b1; eu_write = 1'b1; eu_addr = 20'h0F00E; eu_wdata = 16'h1234; eu_be = 2'b11;
      tick();
      check("eu_wr", 64'(bus_wr), 64'h1);
      check("eu_addr", 64'(bus_addr), 64'h0F00E);
      check("eu_wdata", 64'(bus_wdata), 64'h1234);
      guard = 0;
      while (!eu_done && guard < 20) begin tick(); guard++; end
      check("eu_done_seen", 64'(eu_done), 64'h1);
      eu_req = 1'b0;
      repeat (3) tick();
      check("pf_after_eu", 64'(bus_rd), 64'h1);

      // Randomized traffic, a mid-stream reset, then more traffic.
      for (int i = 0; i < 1500; i++) begin drive_random(1'b1, 1'b1, 1'b1); tick(); end
      reset = 1'b1; eu_req = 1'b0; set_pc = 1'b0; dec_pc = '0;
      tick();
      check("midreset_rd", 64'(bus_rd), 64'h0);
      reset = 1'b0;
      for (int i = 0; i < 1500; i++) begin drive_random(1'b0, 1'b1, 1'b1); tick(); end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
